// File: rtl/alu_pkg.sv
// Shared types and ALU select codes for the two-requester ALU arbiter.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    localparam int FLAG_W = 4;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic overflow, input logic cin,
                                                     input logic cmp, input logic zero);
        return {overflow, cin, cmp, zero};
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals of the arbiter grouped as one bundle.
interface alu_arbiter_if #(
    parameter int W = 4
);
    import alu_pkg::*;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [2:0]        req_op0;
    logic [2:0]        req_op1;
    logic [W-1:0]      req_a0;
    logic [W-1:0]      req_b0;
    logic [W-1:0]      req_a1;
    logic [W-1:0]      req_b1;
    logic [2:0]        alu_select;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [W-1:0]      alu_result;
    logic              alu_zero;
    logic              alu_cin;
    logic              alu_overflow;
    logic              alu_cmp;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [W-1:0]      resp_result;
    logic [FLAG_W-1:0] resp_flags;
    logic              busy;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        output alu_result, alu_zero, alu_cin, alu_overflow, alu_cmp, resp_ready,
        input  req_ready, alu_select, alu_a, alu_b,
        input  resp_valid, resp_id, resp_result, resp_flags, busy
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        input  alu_result, alu_zero, alu_cin, alu_overflow, alu_cmp, resp_ready,
        output req_ready, alu_select, alu_a, alu_b,
        output resp_valid, resp_id, resp_result, resp_flags, busy
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer remembers who won the last accepted request.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);
    logic last;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    // Reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (update) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU: round-robin grant, operands held for
// LAT cycles, then the ALU outputs are captured and offered until the consumer takes them.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W   = 4,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] WAIT_LAST = 2'((LAT > 1) ? LAT - 2 : 0);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        arb_req;
    logic [1:0]        grant;
    logic              accept;
    logic              capture;
    logic              drive_alu;
    logic [2:0]        op_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic              id_q;
    logic [1:0]        wait_cnt;
    logic [W-1:0]      result_q;
    logic [FLAG_W-1:0] flags_q;

    // Requests are only visible to the arbiter while idle, so nothing is queued.
    assign arb_req = (state == IDLE) ? bus.req_valid : 2'b00;
    assign accept  = |grant;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (arb_req),
        .update (accept),
        .grant  (grant)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (LAT == 1) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            wait_cnt <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            if (accept) begin
                id_q <= grant[1];
                op_q <= grant[1] ? bus.req_op1 : bus.req_op0;
                a_q  <= grant[1] ? bus.req_a1  : bus.req_a0;
                b_q  <= grant[1] ? bus.req_b1  : bus.req_b0;
            end
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 2'd1;
            end
            if (capture) begin
                result_q <= bus.alu_result;
                flags_q  <= pack_flags(bus.alu_overflow, bus.alu_cin, bus.alu_cmp, bus.alu_zero);
            end
        end
    end

    assign drive_alu      = (state == ISSUE) || (state == WAIT);
    assign bus.req_ready  = grant;
    assign bus.alu_select = drive_alu ? op_q : 3'b000;
    assign bus.alu_a      = drive_alu ? a_q : '0;
    assign bus.alu_b      = drive_alu ? b_q : '0;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_id    = id_q;
    assign bus.resp_result = result_q;
    assign bus.resp_flags = flags_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: LAT=1 and LAT=3 instances share stimulus, each beside a behavioural ALU,
// checked every cycle against a transaction-level model plus directed literal expectations.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [2:0] req_op0, req_op1;
    logic [3:0] req_a0, req_b0, req_a1, req_b1;
    logic       resp_ready;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_on = 0;

    bit         m_busy[2];
    bit         m_last[2];
    int         m_age[2];
    logic       m_id[2];
    logic [2:0] m_sel[2];
    logic [3:0] m_a[2];
    logic [3:0] m_b[2];
    logic [7:0] m_exp[2];

    alu_arbiter_if #(.W(4)) bus1 ();
    alu_arbiter_if #(.W(4)) bus3 ();

    alu_arbiter #(.W(4), .LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    alu_arbiter #(.W(4), .LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // Returns {result[3:0], overflow, cin, cmp, zero}.
    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic ov, cmp;
        s = 5'd0; ov = 1'b0; cmp = 1'b0;
        case (op)
            OP_ADD: begin s = {1'b0, a} + {1'b0, b};          ov = (a[3] == b[3]) && (s[3] != a[3]); end
            OP_SUB: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1;  ov = (a[3] != b[3]) && (s[3] != a[3]); end
            OP_NOT: s = {1'b0, ~a};
            OP_AND: s = {1'b0, a & b};
            OP_OR:  s = {1'b0, a | b};
            OP_XOR: s = {1'b0, a ^ b};
            OP_LT:  begin cmp = (a < b);  s = {4'b0, cmp}; end
            default: begin cmp = (a == b); s = {4'b0, cmp}; end
        endcase
        return {s[3:0], ov, s[4], cmp, (s[3:0] == 4'd0)};
    endfunction

    function automatic logic [1:0] pick(input logic [1:0] v, input bit last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    assign bus1.req_valid = req_valid;  assign bus3.req_valid = req_valid;
    assign bus1.req_op0 = req_op0;      assign bus3.req_op0 = req_op0;
    assign bus1.req_op1 = req_op1;      assign bus3.req_op1 = req_op1;
    assign bus1.req_a0 = req_a0;        assign bus3.req_a0 = req_a0;
    assign bus1.req_b0 = req_b0;        assign bus3.req_b0 = req_b0;
    assign bus1.req_a1 = req_a1;        assign bus3.req_a1 = req_a1;
    assign bus1.req_b1 = req_b1;        assign bus3.req_b1 = req_b1;
    assign bus1.resp_ready = resp_ready;
    assign bus3.resp_ready = resp_ready;
    assign {bus1.alu_result, bus1.alu_overflow, bus1.alu_cin, bus1.alu_cmp, bus1.alu_zero} =
        alu_fn(bus1.alu_select, bus1.alu_a, bus1.alu_b);
    assign {bus3.alu_result, bus3.alu_overflow, bus3.alu_cin, bus3.alu_cmp, bus3.alu_zero} =
        alu_fn(bus3.alu_select, bus3.alu_a, bus3.alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: age counts cycles since the accepting cycle.
    task automatic model_step(input int k, input int lat, input logic [1:0] rdy, input logic rv,
                              input logic rid, input logic [3:0] rres, input logic [3:0] rflg,
                              input logic bsy, input logic [2:0] sel, input logic [3:0] aa,
                              input logic [3:0] bb);
        logic [1:0] er;
        bit ev;
        string p;
        p  = $sformatf("lat%0d", lat);
        er = m_busy[k] ? 2'b00 : pick(req_valid, m_last[k]);
        ev = m_busy[k] && (m_age[k] >= lat + 1);
        chk({p, " req_ready"}, 32'(rdy), 32'(er));
        chk({p, " busy"}, 32'(bsy), 32'(m_busy[k]));
        chk({p, " resp_valid"}, 32'(rv), 32'(ev));
        if (ev) begin
            chk({p, " resp_id"}, 32'(rid), 32'(m_id[k]));
            chk({p, " resp_result"}, 32'(rres), 32'(m_exp[k][7:4]));
            chk({p, " resp_flags"}, 32'(rflg), 32'(m_exp[k][3:0]));
        end
        if (!m_busy[k]) begin
            chk({p, " alu_idle"}, 32'({sel, aa, bb}), 32'd0);
        end else if (m_age[k] <= lat) begin
            chk({p, " alu_hold"}, 32'({sel, aa, bb}), 32'({m_sel[k], m_a[k], m_b[k]}));
        end
        if (!rst_n) begin
            m_busy[k] = 0; m_last[k] = 1; m_age[k] = 0;
        end else if (er != 2'b00) begin
            m_busy[k] = 1; m_age[k] = 1; m_id[k] = er[1]; m_last[k] = er[1];
            m_sel[k] = er[1] ? req_op1 : req_op0;
            m_a[k]   = er[1] ? req_a1 : req_a0;
            m_b[k]   = er[1] ? req_b1 : req_b0;
            m_exp[k] = alu_fn(m_sel[k], m_a[k], m_b[k]);
        end else if (m_busy[k]) begin
            if (ev && resp_ready) m_busy[k] = 0;
            else m_age[k]++;
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            model_step(0, 1, bus1.req_ready, bus1.resp_valid, bus1.resp_id, bus1.resp_result,
                       bus1.resp_flags, bus1.busy, bus1.alu_select, bus1.alu_a, bus1.alu_b);
            model_step(1, 3, bus3.req_ready, bus3.resp_valid, bus3.resp_id, bus3.resp_result,
                       bus3.resp_flags, bus3.busy, bus3.alu_select, bus3.alu_a, bus3.alu_b);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus1.busy !== 1'b0 || bus3.busy !== 1'b0) && n < 40) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(n < 40), 32'd1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic q[$];
        rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b1;
        req_op0 = OP_ADD; req_op1 = OP_ADD;
        req_a0 = 4'd0; req_b0 = 4'd0; req_a1 = 4'd0; req_b1 = 4'd0;
        tick();
        tick();
        model_on = 1;
        chk("rst req_ready", 32'(bus1.req_ready), 32'd0);
        chk("rst resp_valid", 32'(bus1.resp_valid), 32'd0);
        chk("rst resp_fields", 32'({bus1.resp_id, bus1.resp_result, bus1.resp_flags}), 32'd0);
        chk("rst alu", 32'({bus1.alu_select, bus1.alu_a, bus1.alu_b}), 32'd0);
        chk("rst busy", 32'({bus1.busy, bus3.busy}), 32'd0);
        chk("rst lat3 resp_fields", 32'({bus3.resp_valid, bus3.resp_id, bus3.resp_result, bus3.resp_flags}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single requester 0: ADD 3+4.
        req_valid = 2'b01; req_op0 = OP_ADD; req_a0 = 4'd3; req_b0 = 4'd4;
        tick();
        req_valid = 2'b00;
        chk("add34 early resp_valid", 32'(bus1.resp_valid), 32'd0);
        tick();
        chk("add34 resp_valid", 32'(bus1.resp_valid), 32'd1);
        chk("add34 resp_id", 32'(bus1.resp_id), 32'd0);
        chk("add34 result", 32'(bus1.resp_result), 32'd7);
        chk("add34 flags", 32'(bus1.resp_flags), 32'b0000);
        wait_idle();

        // Requester 1: SUB 5-5.
        req_valid = 2'b10; req_op1 = OP_SUB; req_a1 = 4'd5; req_b1 = 4'd5;
        tick();
        req_valid = 2'b00;
        tick();
        chk("sub55 resp_valid", 32'(bus1.resp_valid), 32'd1);
        chk("sub55 resp_id", 32'(bus1.resp_id), 32'd1);
        chk("sub55 result", 32'(bus1.resp_result), 32'd0);
        chk("sub55 flags", 32'(bus1.resp_flags), 32'b0101);
        wait_idle();

        // Wrap-around: ADD F+1.
        req_valid = 2'b01; req_op0 = OP_ADD; req_a0 = 4'hF; req_b0 = 4'd1;
        tick();
        req_valid = 2'b00;
        tick();
        chk("addF1 result", 32'(bus1.resp_result), 32'd0);
        chk("addF1 flags", 32'(bus1.resp_flags), 32'b0101);
        wait_idle();

        // Both requesters always valid after a fresh reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_valid = 2'b11; req_op0 = OP_XOR; req_a0 = 4'd9; req_b0 = 4'd3;
        req_op1 = OP_LT; req_a1 = 4'd2; req_b1 = 4'd7;
        for (int i = 0; i < 16 && q.size() < 4; i++) begin
            #1;
            if (bus1.req_ready !== 2'b00) q.push_back(bus1.req_ready[1]);
            tick();
        end
        req_valid = 2'b00;
        chk("rr grant_count", 32'(q.size()), 32'd4);
        for (int i = 0; i < q.size() && i < 4; i++) begin
            chk($sformatf("rr grant%0d", i), 32'(q[i]), 32'(i % 2));
        end
        wait_idle();

        // Consumer stalls for 5 cycles while requester 1 waits.
        resp_ready = 1'b0;
        req_valid = 2'b01; req_op0 = OP_ADD; req_a0 = 4'd2; req_b0 = 4'd3;
        tick();
        req_valid = 2'b10;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall resp_valid", 32'(bus1.resp_valid), 32'd1);
            chk("stall result", 32'({bus1.resp_id, bus1.resp_result, bus1.resp_flags}), 32'({1'b0, 4'd5, 4'b0000}));
            chk("stall req_ready", 32'(bus1.req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        req_valid = 2'b00;
        tick();
        chk("stall released", 32'(bus1.resp_valid), 32'd0);
        wait_idle();

        // Reset while the LAT=3 instance sits in WAIT.
        req_valid = 2'b01; req_op0 = OP_ADD; req_a0 = 4'd6; req_b0 = 4'd1;
        tick();
        req_valid = 2'b00;
        tick();
        chk("lat3 busy before reset", 32'(bus3.busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("lat3 after reset", 32'({bus3.busy, bus3.resp_valid, bus3.resp_result}), 32'd0);
        req_valid = 2'b11; req_op0 = OP_ADD; req_a0 = 4'd1; req_b0 = 4'd1;
        req_op1 = OP_ADD; req_a1 = 4'd2; req_b1 = 4'd2;
        #1;
        chk("lat3 tie after reset", 32'(bus3.req_ready), 32'b01);
        tick();
        req_valid = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("lat3 resp_valid age%0d", i), 32'(bus3.resp_valid), 32'(i == 4));
            if (i < 4) tick();
        end
        chk("lat3 result", 32'(bus3.resp_result), 32'd2);
        wait_idle();

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
